// File: rtl/aibnd_dll_ctrl.sv
// DLL/DCC calibration controller: pulses the phase detector, steps a 10-bit delay code, declares lock after a dither.
// Optional tracking while locked is enabled with `define AIBND_DLL_TRACK_EN.
module aibnd_dll_ctrl #(
  parameter int SETTLE_CYC     = 8,
  parameter int LOCK_TOGGLES   = 4,
  parameter int INIT_CODE      = 512,
  parameter int TRACK_INTERVAL = 64
) (
  input  logic       clk_dcd,
  input  logic       dll_reset,
  input  logic       dll_en,
  input  logic       t_up,
  input  logic       t_down,
  output logic       launch,
  output logic       measure,
  output logic       pd_reset_n,
  output logic [2:0] i_gray,
  output logic [6:0] f_gray,
  output logic [9:0] pvt_ref_half_gry,
  output logic       dll_lock,
  output logic       dll_sat,
  output logic [9:0] code_bin
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_MEASURE, S_EVAL, S_LOCKED} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  function automatic logic [2:0] gray3(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [6:0] gray7(input logic [6:0] b);
    return b ^ (b >> 1);
  endfunction

  // Half-delay reference: coarse gray in the low bits, fine gray above it.
  function automatic logic [9:0] half_gray(input logic [9:0] c);
    logic [9:0] h;
    h = c >> 1;
    return {gray7(h[6:0]), gray3(h[9:7])};
  endfunction

  state_t     state_reg;
  dir_t       prev_dir_reg;
  logic [9:0] code_reg;
  logic [7:0] wait_cnt_reg;
  logic [3:0] toggle_cnt_reg;
  logic       launch_reg;
  logic       measure_reg;
  logic       pd_reset_n_reg;
  logic       dll_lock_reg;
  logic       dll_sat_reg;
  logic [9:0] half_gry_reg;

  dir_t       eval_dir;
  logic       at_bound;
  logic       opposite;
  logic       lock_hit;
  logic [9:0] code_next;
  logic [4:0] toggle_inc;
  logic       track_iter;

  always_comb begin
    eval_dir = DIR_NONE;
    if (t_up && !t_down)
      eval_dir = DIR_UP;
    else if (t_down && !t_up)
      eval_dir = DIR_DN;

    at_bound = ((eval_dir == DIR_UP) && (code_reg == 10'd1023)) ||
               ((eval_dir == DIR_DN) && (code_reg == 10'd0));

    code_next = code_reg;
    if (!at_bound && (eval_dir == DIR_UP))
      code_next = code_reg + 10'd1;
    else if (!at_bound && (eval_dir == DIR_DN))
      code_next = code_reg - 10'd1;

    toggle_inc = {1'b0, toggle_cnt_reg} + 5'd1;
    opposite   = (eval_dir != DIR_NONE) && (prev_dir_reg != DIR_NONE) && (eval_dir != prev_dir_reg);
    lock_hit   = opposite && !at_bound && (toggle_inc == 5'(LOCK_TOGGLES));
  end

`ifdef AIBND_DLL_TRACK_EN
  logic [15:0] track_cnt_reg;
  logic        tracking_reg;

  assign track_iter = tracking_reg;

  always_ff @(posedge clk_dcd) begin
    if (dll_reset) begin
      track_cnt_reg <= '0;
      tracking_reg  <= 1'b0;
    end else if (!dll_en) begin
      track_cnt_reg <= '0;
      tracking_reg  <= 1'b0;
    end else if (state_reg == S_LOCKED) begin
      if (track_cnt_reg == 16'(TRACK_INTERVAL - 1)) begin
        track_cnt_reg <= '0;
        tracking_reg  <= 1'b1;
      end else begin
        track_cnt_reg <= track_cnt_reg + 16'd1;
      end
    end else if (state_reg == S_EVAL) begin
      tracking_reg <= 1'b0;
    end
  end

  logic track_fire;
  assign track_fire = (track_cnt_reg == 16'(TRACK_INTERVAL - 1));
`else
  // Tracking disabled: LOCKED is terminal.
  assign track_iter = 1'b0 & (TRACK_INTERVAL < 1);
  logic track_fire;
  assign track_fire = 1'b0;
`endif

  always_ff @(posedge clk_dcd) begin
    if (dll_reset) begin
      state_reg      <= S_IDLE;
      prev_dir_reg   <= DIR_NONE;
      code_reg       <= 10'(INIT_CODE);
      wait_cnt_reg   <= '0;
      toggle_cnt_reg <= '0;
      launch_reg     <= 1'b0;
      measure_reg    <= 1'b0;
      pd_reset_n_reg <= 1'b0;
      dll_lock_reg   <= 1'b0;
      dll_sat_reg    <= 1'b0;
      half_gry_reg   <= '0;
    end else begin
      launch_reg  <= 1'b0;
      measure_reg <= 1'b0;
      if ((state_reg != S_IDLE) && !dll_en) begin
        state_reg      <= S_IDLE;
        pd_reset_n_reg <= 1'b0;
        dll_lock_reg   <= 1'b0;
        toggle_cnt_reg <= '0;
        prev_dir_reg   <= DIR_NONE;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (dll_en) begin
              state_reg      <= S_LAUNCH;
              launch_reg     <= 1'b1;
              pd_reset_n_reg <= 1'b1;
            end
          end
          S_LAUNCH: begin
            state_reg    <= S_WAIT;
            wait_cnt_reg <= '0;
          end
          S_WAIT: begin
            if (wait_cnt_reg == 8'(SETTLE_CYC - 1)) begin
              state_reg   <= S_MEASURE;
              measure_reg <= 1'b1;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
          end
          S_MEASURE: state_reg <= S_EVAL;
          S_EVAL: begin
            code_reg <= code_next;
            if (at_bound)
              dll_sat_reg <= 1'b1;
            if (track_iter) begin
              // A tracking step refreshes the reference but leaves the dither history alone.
              state_reg    <= S_LOCKED;
              half_gry_reg <= half_gray(code_next);
            end else begin
              if (eval_dir != DIR_NONE) begin
                prev_dir_reg <= eval_dir;
                if (at_bound || (eval_dir == prev_dir_reg))
                  toggle_cnt_reg <= '0;
                else if (opposite)
                  toggle_cnt_reg <= toggle_inc[3:0];
              end
              if (lock_hit) begin
                state_reg    <= S_LOCKED;
                dll_lock_reg <= 1'b1;
                half_gry_reg <= half_gray(code_next);
              end else begin
                state_reg  <= S_LAUNCH;
                launch_reg <= 1'b1;
              end
            end
          end
          S_LOCKED: begin
            if (track_fire) begin
              state_reg  <= S_LAUNCH;
              launch_reg <= 1'b1;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign launch           = launch_reg;
  assign measure          = measure_reg;
  assign pd_reset_n       = pd_reset_n_reg;
  assign dll_lock         = dll_lock_reg;
  assign dll_sat          = dll_sat_reg;
  assign pvt_ref_half_gry = half_gry_reg;
  assign code_bin         = code_reg;
  assign i_gray           = gray3(code_reg[9:7]);
  assign f_gray           = gray7(code_reg[6:0]);

endmodule

// File: tb/tb_aibnd_dll_ctrl.sv
// Directed bench for aibnd_dll_ctrl: reset, pulse timing, dither lock, saturation, enable drop and reset override.
module tb_aibnd_dll_ctrl;

  logic       clk = 1'b0;
  logic       dll_reset, dll_en, t_up, t_down;
  logic       launch, measure, pd_reset_n, dll_lock, dll_sat;
  logic [2:0] i_gray;
  logic [6:0] f_gray;
  logic [9:0] pvt_ref_half_gry, code_bin;

  logic       en_s, up_s;
  logic       launch_s, measure_s, pd_reset_n_s, dll_lock_s, dll_sat_s;
  logic [2:0] i_gray_s;
  logic [6:0] f_gray_s;
  logic [9:0] pvt_s, code_s;

  int checks = 0;
  int failures = 0;
  int exp_code;

`ifdef AIBND_DLL_TRACK_EN
  localparam logic [9:0] FINAL_PVT = 10'h00B;
`else
  localparam logic [9:0] FINAL_PVT = 10'h003;
`endif

  always #5 clk = ~clk;

  aibnd_dll_ctrl #(.SETTLE_CYC(8), .LOCK_TOGGLES(4), .INIT_CODE(512), .TRACK_INTERVAL(64)) dut (
    .clk_dcd(clk), .dll_reset(dll_reset), .dll_en(dll_en), .t_up(t_up), .t_down(t_down),
    .launch(launch), .measure(measure), .pd_reset_n(pd_reset_n), .i_gray(i_gray), .f_gray(f_gray),
    .pvt_ref_half_gry(pvt_ref_half_gry), .dll_lock(dll_lock), .dll_sat(dll_sat), .code_bin(code_bin)
  );

  aibnd_dll_ctrl #(.SETTLE_CYC(8), .LOCK_TOGGLES(4), .INIT_CODE(1022), .TRACK_INTERVAL(64)) dut_s (
    .clk_dcd(clk), .dll_reset(dll_reset), .dll_en(en_s), .t_up(up_s), .t_down(1'b0),
    .launch(launch_s), .measure(measure_s), .pd_reset_n(pd_reset_n_s), .i_gray(i_gray_s), .f_gray(f_gray_s),
    .pvt_ref_half_gry(pvt_s), .dll_lock(dll_lock_s), .dll_sat(dll_sat_s), .code_bin(code_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One calibration iteration: wait for measure, present the decision across EVAL, check the result.
  task automatic run_iter(input logic up, input logic dn, input int exp_c, input logic exp_lock);
    int n = 0;
    while (!measure && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("measure_seen", 32'(measure), 1);
    t_up = up;
    t_down = dn;
    @(negedge clk);
    @(negedge clk);
    t_up = 1'b0;
    t_down = 1'b0;
    check("iter_code", 32'(code_bin), 32'(exp_c));
    check("iter_lock", 32'(dll_lock), 32'(exp_lock));
    $display("iter up=%0d dn=%0d code=%0d lock=%0d", up, dn, code_bin, dll_lock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    dll_reset = 1'b1; dll_en = 1'b0; t_up = 1'b0; t_down = 1'b0;
    en_s = 1'b0; up_s = 1'b0;
    repeat (3) @(negedge clk);
    dll_reset = 1'b0;
    @(negedge clk);
    check("rst_code", 32'(code_bin), 512);
    check("rst_i_gray", 32'(i_gray), 32'b110);
    check("rst_f_gray", 32'(f_gray), 0);
    check("rst_pvt", 32'(pvt_ref_half_gry), 0);
    check("rst_lock", 32'(dll_lock), 0);
    check("rst_pd_reset_n", 32'(pd_reset_n), 0);
    check("rst_launch", 32'(launch), 0);
    check("rst_measure", 32'(measure), 0);
    check("rst_sat", 32'(dll_sat), 0);
    check("rst_s_code", 32'(code_s), 1022);
    check("rst_s_i_gray", 32'(i_gray_s), 32'b100);
    check("rst_s_f_gray", 32'(f_gray_s), 32'b1000001);

    en_s = 1'b1; up_s = 1'b1;
    dll_en = 1'b1;
    @(negedge clk);
    check("c1_launch", 32'(launch), 1);
    check("c1_pd_reset_n", 32'(pd_reset_n), 1);
    check("c1_measure", 32'(measure), 0);
    repeat (8) @(negedge clk);
    check("c9_measure", 32'(measure), 0);
    @(negedge clk);
    check("c10_measure", 32'(measure), 1);
    check("c10_launch", 32'(launch), 0);
    @(negedge clk);
    check("c11_launch", 32'(launch), 0);
    @(negedge clk);
    check("c12_launch", 32'(launch), 1);
    check("c12_code_nostep", 32'(code_bin), 512);

    run_iter(1'b1, 1'b0, 513, 1'b0);
    run_iter(1'b0, 1'b1, 512, 1'b0);
    run_iter(1'b1, 1'b0, 513, 1'b0);
    run_iter(1'b0, 1'b1, 512, 1'b0);
    run_iter(1'b1, 1'b0, 513, 1'b1);
    check("lock_pvt", 32'(pvt_ref_half_gry), 32'h003);
    check("lock_i_gray", 32'(i_gray), 32'b110);
    check("lock_f_gray", 32'(f_gray), 1);
    check("lock_pd_reset_n", 32'(pd_reset_n), 1);

`ifdef AIBND_DLL_TRACK_EN
    begin
      int n = 0;
      while (!launch && n < 80) begin
        @(negedge clk);
        n++;
        check("track_lock_held", 32'(dll_lock), 1);
      end
      check("track_launch_seen", 32'(launch), 1);
      check("track_interval", 32'(n), 64);
    end
    run_iter(1'b1, 1'b0, 514, 1'b1);
    check("track_pvt", 32'(pvt_ref_half_gry), 32'h00B);
    exp_code = 514;
`else
    begin
      int lc = 0;
      repeat (40) begin
        @(negedge clk);
        if (launch) lc++;
      end
      check("locked_no_launch", 32'(lc), 0);
    end
    check("locked_lock", 32'(dll_lock), 1);
    check("locked_code", 32'(code_bin), 513);
    exp_code = 513;
`endif

    dll_en = 1'b0;
    @(negedge clk);
    check("dis_lock", 32'(dll_lock), 0);
    check("dis_pd_reset_n", 32'(pd_reset_n), 0);
    check("dis_launch", 32'(launch), 0);
    check("dis_code", 32'(code_bin), 32'(exp_code));
    @(negedge clk);
    dll_en = 1'b1;
    @(negedge clk);
    check("reen_launch", 32'(launch), 1);
    run_iter(1'b0, 1'b1, exp_code - 1, 1'b0);
    run_iter(1'b1, 1'b0, exp_code, 1'b0);
    run_iter(1'b0, 1'b1, exp_code - 1, 1'b0);
    @(negedge clk);
    check("wait_launch", 32'(launch), 0);
    dll_en = 1'b0;
    @(negedge clk);
    check("drop_pd_reset_n", 32'(pd_reset_n), 0);
    check("drop_launch", 32'(launch), 0);
    check("drop_code", 32'(code_bin), 32'(exp_code - 1));
    dll_en = 1'b1;
    @(negedge clk);
    check("drop_reen_launch", 32'(launch), 1);
    run_iter(1'b1, 1'b0, exp_code, 1'b0);
    run_iter(1'b0, 1'b1, exp_code - 1, 1'b0);
    run_iter(1'b1, 1'b0, exp_code, 1'b0);
    run_iter(1'b0, 1'b1, exp_code - 1, 1'b0);
    run_iter(1'b1, 1'b0, exp_code, 1'b1);
    check("relock_pvt", 32'(pvt_ref_half_gry), 32'(FINAL_PVT));
    check("main_sat", 32'(dll_sat), 0);

    check("sat_code", 32'(code_s), 1023);
    check("sat_flag", 32'(dll_sat_s), 1);
    check("sat_lock", 32'(dll_lock_s), 0);
    check("sat_i_gray", 32'(i_gray_s), 32'b100);
    check("sat_f_gray", 32'(f_gray_s), 32'b1000000);

    dll_en = 1'b0;
    @(negedge clk);
    dll_en = 1'b1;
    dll_reset = 1'b1;
    @(negedge clk);
    check("ovr_launch", 32'(launch), 0);
    check("ovr_code", 32'(code_bin), 512);
    check("ovr_lock", 32'(dll_lock), 0);
    check("ovr_pvt", 32'(pvt_ref_half_gry), 0);
    check("ovr_pd_reset_n", 32'(pd_reset_n), 0);
    dll_reset = 1'b0;
    @(negedge clk);
    check("post_rst_launch", 32'(launch), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
